ps2_host_tx: RTL and testbench
==============================

// Module: ps2_host_tx
// PURPOSE
//   Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable)
//   from the FPGA to the keyboard over the shared ps2c/ps2d open-drain lines.
//   Counterpart of the keyboard receive path; busy tells the receiver to ignore line activity.
//   Performs the inhibit/request-to-send sequence, clocks out bits on device-generated clock
//   edges, and checks the device acknowledge.
// PARAMETERS
//   INHIBIT_CYCLES  5000    clk cycles ps2c is held low before request-to-send (100 us @ 50 MHz)
//   REQ_CYCLES      250     clk cycles ps2d is held low with ps2c still low, before ps2c is released
//   TIMEOUT_CYCLES  750000  max clk cycles between consecutive device falling edges (15 ms)
//   FILTER_LEN      8       consecutive equal synced samples needed to change the filtered ps2c
// PORTS
//   clk              in   1  system clock, 50 MHz
//   rst_n            in   1  asynchronous active-low reset
//   tx_data          in   8  command byte
//   tx_valid         in   1  request to send tx_data
//   tx_ready         out  1  high only in IDLE; a byte is accepted when tx_valid && tx_ready
//   ps2c_in          in   1  PS/2 clock pad value (async)
//   ps2d_in          in   1  PS/2 data pad value (async)
//   ps2c_drive_low   out  1  1 = pull ps2c low, 0 = release (pad tri-stated)
//   ps2d_drive_low   out  1  1 = pull ps2d low, 0 = release
//   busy             out  1  high in every state except IDLE
//   tx_done          out  1  1-cycle pulse: byte sent and device acked
//   tx_error         out  1  1-cycle pulse: transfer aborted
//   err_code         out  2  valid with tx_error, held until next accept: 01 timeout, 10 no ack
// BEHAVIOUR
//   Reset, async: state IDLE. Both drive_low = 0, tx_ready = 1, busy = 0, tx_done = tx_error = 0,
//     err_code = 00, filtered ps2c = 1. Reset mid-transfer releases both lines immediately.
//   Input path: ps2c_in and ps2d_in each pass through a 2-FF synchronizer. ps2c also passes the
//     FILTER_LEN debounce. fall = filtered ps2c 1->0, one cycle.
//   Accept: on the accept cycle tx_data is latched. parity = ~^tx_data (odd parity).
//     The next cycle is INHIBIT; tx_ready = 0 from then on.
//     tx_valid outside IDLE is ignored. There is no queue.
//   FSM:
//     IDLE    -> INHIBIT on accept.
//     INHIBIT  ps2c_drive_low = 1 for exactly INHIBIT_CYCLES cycles -> REQ.
//     REQ      ps2c_drive_low = 1 and ps2d_drive_low = 1 for REQ_CYCLES cycles.
//              Then ps2c is released (ps2d stays low as the start bit) -> DATA, timeout counter cleared.
//     DATA     on each fall, present the next bit: ps2d_drive_low = ~bit, d0 first (LSB).
//              After d7 is presented -> PARITY.
//     PARITY   on fall, ps2d_drive_low = ~parity -> STOP.
//     STOP     on fall, ps2d_drive_low = 0 (stop bit = released) -> ACK.
//     ACK      on fall, sample synced ps2d. If 0 -> WAITIDLE; if 1 -> ERROR with code 10.
//     WAITIDLE wait for synced ps2d = 1 and filtered ps2c = 1 -> DONE.
//     DONE     tx_done = 1 for one cycle -> IDLE.
//     ERROR    both lines released, tx_error = 1 for one cycle -> IDLE.
//   Timeout: the counter runs from DATA through WAITIDLE and is cleared on every fall.
//     At TIMEOUT_CYCLES -> ERROR with code 01. The timeout wins over a fall in the same cycle.
//   Drive outputs are registered; a new bit value appears 1 clk after the fall is detected.
//     ps2c_drive_low is never 1 outside INHIBIT/REQ.
//   Counters are sized for their parameter (timeout: 20 bits at the default). No wrap is allowed.
// TESTING
//   1 tx 0xED, device model clocks at 12 kHz and acks -> ps2c low exactly 5000 cycles; d0..d7
//     on line = 1,0,1,1,0,1,1,1; parity 1; stop released; tx_done 1-cycle pulse; err_code 00.
//   2 tx 0xF4 -> bits 0,0,1,0,1,1,1,1; parity bit 0 (ps2d_drive_low = 1 during parity cell);
//     tx_done pulse.
//   3 device leaves ps2d high on 11th falling edge -> tx_error pulse, err_code 10,
//     both drive_low 0, tx_ready 1 next cycle.
//   4 device never clocks after REQ -> tx_error exactly TIMEOUT_CYCLES after ps2c release,
//     err_code 01, lines released.
//   5 rst_n low mid-DATA (after d3) -> both drive_low 0 without waiting for clk; after release:
//     IDLE, tx_ready 1; a new 0xF4 transfer completes correctly.
//   6 tx_valid pulsed with 0x00 while busy -> ignored (original byte sent).
//     A 3-cycle ps2c glitch -> no fall, bit count unchanged.

Source files
------------

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, clock out 8 data bits + odd parity + stop
// on device falling edges, then check the device acknowledge. Line drives are registered.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int REQ_CYCLES     = 250,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_drive_low,
  output logic       ps2d_drive_low,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error,
  output logic [1:0] err_code
);

  localparam int PH_MAX = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam int TO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int FL_W   = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_DATA, S_PARITY, S_STOP, S_ACK, S_WAITIDLE, S_DONE, S_ERROR
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      c_sync_q, d_sync_q;
  logic [FL_W-1:0] flt_cnt_q, flt_cnt_d;
  logic            c_flt_q, c_flt_d, c_flt_prev_q;
  logic [7:0]      data_q, data_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [PH_W-1:0] ph_cnt_q, ph_cnt_d;
  logic [TO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic            ps2c_drive_q, ps2c_drive_d;
  logic            ps2d_drive_q, ps2d_drive_d;
  logic [1:0]      err_q, err_d;

  logic c_s, d_s, fall, accept, timed, tmo_hit, parity;

  assign c_s     = c_sync_q[1];
  assign d_s     = d_sync_q[1];
  assign fall    = c_flt_prev_q & ~c_flt_q;
  assign accept  = tx_valid && (state_q == S_IDLE);
  assign timed   = state_q inside {S_DATA, S_PARITY, S_STOP, S_ACK, S_WAITIDLE};
  assign tmo_hit = timed && (tmo_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
  assign parity  = ~^data_q;

  // ps2c only changes after FILTER_LEN consecutive disagreeing synced samples
  always_comb begin
    flt_cnt_d = '0;
    c_flt_d   = c_flt_q;
    if (c_s != c_flt_q) begin
      if (flt_cnt_q == FL_W'(FILTER_LEN - 1)) c_flt_d = c_s;
      else                                    flt_cnt_d = flt_cnt_q + FL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:     if (tx_valid) state_d = S_INHIBIT;
      S_INHIBIT:  if (ph_cnt_q == PH_W'(INHIBIT_CYCLES - 1)) state_d = S_REQ;
      S_REQ:      if (ph_cnt_q == PH_W'(REQ_CYCLES - 1)) state_d = S_DATA;
      S_DATA:     if (tmo_hit) state_d = S_ERROR;
                  else if (fall && bit_cnt_q == 3'd7) state_d = S_PARITY;
      S_PARITY:   if (tmo_hit) state_d = S_ERROR;
                  else if (fall) state_d = S_STOP;
      S_STOP:     if (tmo_hit) state_d = S_ERROR;
                  else if (fall) state_d = S_ACK;
      S_ACK:      if (tmo_hit) state_d = S_ERROR;
                  else if (fall) state_d = d_s ? S_ERROR : S_WAITIDLE;
      S_WAITIDLE: if (tmo_hit) state_d = S_ERROR;
                  else if (d_s && c_flt_q) state_d = S_DONE;
      S_DONE:     state_d = S_IDLE;
      S_ERROR:    state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tx_ready = (state_q == S_IDLE);
    busy     = (state_q != S_IDLE);
    tx_done  = (state_q == S_DONE);
    tx_error = (state_q == S_ERROR);

    data_d    = accept ? tx_data : data_q;
    bit_cnt_d = bit_cnt_q;
    if (accept) bit_cnt_d = '0;
    else if (state_q == S_DATA && fall && !tmo_hit && bit_cnt_q != 3'd7)
      bit_cnt_d = bit_cnt_q + 3'd1;

    ph_cnt_d  = (state_d != state_q || !(state_q inside {S_INHIBIT, S_REQ}))
                ? '0 : ph_cnt_q + PH_W'(1);
    tmo_cnt_d = (!timed || fall) ? '0 : tmo_cnt_q + TO_W'(1);

    ps2c_drive_d = (state_d inside {S_INHIBIT, S_REQ});
    // ps2d stays low from REQ through DATA entry: that low level is the start bit
    ps2d_drive_d = ps2d_drive_q;
    if (state_d inside {S_IDLE, S_INHIBIT, S_ACK, S_WAITIDLE, S_DONE, S_ERROR})
      ps2d_drive_d = 1'b0;
    else if (state_d == S_REQ)
      ps2d_drive_d = 1'b1;
    else if (fall && state_q == S_DATA)
      ps2d_drive_d = ~data_q[bit_cnt_q];
    else if (fall && state_q == S_PARITY)
      ps2d_drive_d = ~parity;

    err_d = err_q;
    if (accept) err_d = 2'b00;
    else if (state_q != S_ERROR && state_d == S_ERROR) err_d = tmo_hit ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_sync_q     <= 2'b11;
      d_sync_q     <= 2'b11;
      flt_cnt_q    <= '0;
      c_flt_q      <= 1'b1;
      c_flt_prev_q <= 1'b1;
      data_q       <= '0;
      bit_cnt_q    <= '0;
      ph_cnt_q     <= '0;
      tmo_cnt_q    <= '0;
      ps2c_drive_q <= 1'b0;
      ps2d_drive_q <= 1'b0;
      err_q        <= 2'b00;
    end else begin
      c_sync_q     <= {c_sync_q[0], ps2c_in};
      d_sync_q     <= {d_sync_q[0], ps2d_in};
      flt_cnt_q    <= flt_cnt_d;
      c_flt_q      <= c_flt_d;
      c_flt_prev_q <= c_flt_q;
      data_q       <= data_d;
      bit_cnt_q    <= bit_cnt_d;
      ph_cnt_q     <= ph_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      ps2c_drive_q <= ps2c_drive_d;
      ps2d_drive_q <= ps2d_drive_d;
      err_q        <= err_d;
    end
  end

  assign ps2c_drive_low = ps2c_drive_q;
  assign ps2d_drive_low = ps2d_drive_q;
  assign err_code       = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboarded bench for ps2_host_tx with an open-drain PS/2 device model.
module tb_ps2_host_tx;

  localparam int INH  = 60;
  localparam int REQ  = 12;
  localparam int TMO  = 3000;
  localparam int HALF = 50;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, busy, tx_done, tx_error;
  logic       ps2c_drive_low, ps2d_drive_low;
  logic [1:0] err_code;
  logic       dev_c, dev_d;
  logic       ps2c_line, ps2d_line;

  assign ps2c_line = ~(ps2c_drive_low | dev_c);
  assign ps2d_line = ~(ps2d_drive_low | dev_d);

  always #5 clk = ~clk;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .REQ_CYCLES(REQ), .TIMEOUT_CYCLES(TMO), .FILTER_LEN(8)) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .ps2c_in(ps2c_line), .ps2d_in(ps2d_line), .ps2c_drive_low(ps2c_drive_low),
    .ps2d_drive_low(ps2d_drive_low), .busy(busy), .tx_done(tx_done), .tx_error(tx_error),
    .err_code(err_code)
  );

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       is_err;
    logic [1:0] err;
    bit         frame;
    bit         tmo;
  } exp_t;

  exp_t       exp_q[$];
  int         total = 0;
  int         bad   = 0;
  logic [9:0] cap;
  logic       cap_start;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Device: waits for ps2c release, then generates n_falls clock pulses, sampling on rising edges
  task automatic dev_run(input bit ack_ok, input bit glitch, input int n_falls);
    cap = 'x;
    cap_start = 1'bx;
    for (int i = 0; i < 400 && !ps2c_drive_low; i++) tick(1);
    for (int i = 0; i < 400 && ps2c_drive_low; i++) tick(1);
    cap_start = ps2d_line;
    for (int k = 0; k < n_falls; k++) begin
      if (k == 10) begin
        tick(HALF - 5); dev_d = ack_ok; tick(5);
      end else if (glitch && k == 3) begin
        tick(10); dev_c = 1'b1; tick(3); dev_c = 1'b0; tick(HALF - 13);
      end else begin
        tick(HALF);
      end
      dev_c = 1'b1;
      tick(HALF);
      dev_c = 1'b0;
      if (k < 10) cap[k] = ps2d_line;
    end
    tick(5);
    dev_d = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input logic par, input logic is_err,
                      input logic [1:0] err, input bit frame, input bit tmo, input bit push);
    exp_t e;
    check("ready_before_send", tx_ready, 1'b1);
    e.data = d; e.par = par; e.is_err = is_err; e.err = err; e.frame = frame; e.tmo = tmo;
    if (push) exp_q.push_back(e);
    tx_data  = d;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n && exp_q.size() != 0; i++) tick(1);
    check("drain", exp_q.size(), 0);
    tick(20);
  endtask

  // Monitor: counts inhibit/request cells, timestamps ps2c release, scores each done/error pulse
  initial begin
    int   cyc = 0, inh = 0, req = 0, rel_cyc = 0;
    logic c_prev = 1'b0;
    bit   post = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (tx_valid && tx_ready) begin
        inh = 0; req = 0;
      end else begin
        if (ps2c_drive_low && !ps2d_drive_low) inh++;
        if (ps2c_drive_low && ps2d_drive_low) req++;
      end
      if (c_prev && !ps2c_drive_low) rel_cyc = cyc;
      c_prev = ps2c_drive_low;
      if (post) begin
        post = 1'b0;
        check("pulse_width", {tx_done, tx_error}, 2'b00);
        check("ready_after", tx_ready, 1'b1);
        check("lines_after", {ps2c_drive_low, ps2d_drive_low}, 2'b00);
      end
      if (tx_done || tx_error) begin
        post = 1'b1;
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", {tx_done, tx_error}, 2'b00);
        end else begin
          e = exp_q.pop_front();
          check("outcome", {tx_done, tx_error}, e.is_err ? 2'b01 : 2'b10);
          check("err_code", err_code, e.err);
          check("busy_at_pulse", busy, 1'b1);
          check("inhibit_cycles", inh, INH);
          check("req_cycles", req, REQ);
          if (e.frame) begin
            check("start_bit", cap_start, 1'b0);
            check("data_bits", cap[7:0], e.data);
            check("parity_bit", cap[8], e.par);
            check("stop_bit", cap[9], 1'b1);
          end
          if (e.tmo) check("timeout_latency", cyc - rel_cyc, TMO);
        end
      end
    end
  end

  initial begin
    repeat (60000) @(posedge clk);
    bad++; total++;
    $display("FAIL watchdog: got no finish expected finish within 60000 cycles");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    rst_n = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; dev_c = 1'b0; dev_d = 1'b0;
    tick(3);
    check("rst_ready", tx_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_lines", {ps2c_drive_low, ps2d_drive_low}, 2'b00);
    check("rst_pulses", {tx_done, tx_error}, 2'b00);
    check("rst_err", err_code, 2'b00);
    rst_n = 1'b1;
    tick(5);

    // 0xED: lines d0..d7 = 1,0,1,1,0,1,1,1, parity 1
    send(8'hED, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1);
    dev_run(1'b1, 1'b0, 11);
    drain(500);

    // 0xF4: parity 0
    send(8'hF4, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1);
    dev_run(1'b1, 1'b0, 11);
    drain(500);

    // 0x5A with device withholding the ack
    send(8'h5A, 1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1);
    dev_run(1'b0, 1'b0, 11);
    drain(500);

    // device never clocks
    send(8'h01, 1'b0, 1'b1, 2'b01, 1'b0, 1'b1, 1'b1);
    drain(TMO + 500);
    tick(10);
    check("err_code_held", err_code, 2'b01);

    // reset after d3 has been presented
    send(8'hED, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
    dev_run(1'b1, 1'b0, 4);
    tick(20);
    check("busy_before_reset", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("reset_lines_async", {ps2c_drive_low, ps2d_drive_low}, 2'b00);
    tick(3);
    rst_n = 1'b1;
    tick(2);
    check("reset_ready", tx_ready, 1'b1);
    check("reset_busy", busy, 1'b0);
    send(8'hF4, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1);
    dev_run(1'b1, 1'b0, 11);
    drain(500);

    // 0xA5 with a 0x00 request while busy and a 3-cycle ps2c glitch
    send(8'hA5, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1);
    fork
      dev_run(1'b1, 1'b1, 11);
      begin
        tick(20);
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
      end
    join
    drain(500);
    check("idle_at_end", tx_ready, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
